ps2_host_tx: RTL
================

// Module: ps2_host_tx
// PURPOSE
//  PS/2 host-to-device transmitter: the sending end of the keyboard link whose
//  receive side is the keyboard FSM. Sends one command byte (e.g. 0xED set-LEDs,
//  0xFF reset) by inhibiting the bus, issuing a request-to-send, shifting the
//  frame on device-generated clocks and checking the device ACK. Sits in the
//  top level beside the keyboard FSM, on the same PS2_CLK/PS2_DAT pins.
// PARAMETERS
//  CLK_HZ      50000000  system clock frequency, Hz
//  INHIBIT_US  120       hold time for ps2_clk low before the request, us
//  TIMEOUT_US  15000     watchdog from clk release to ACK-phase end, us
// PORTS
//  clk         in   1  system clock (CLOCK_50)
//  reset       in   1  synchronous, active-high reset
//  tx_data     in   8  command byte
//  tx_valid    in   1  request; accepted when tx_valid && tx_ready
//  tx_ready    out  1  high only in IDLE
//  ps2_clk_in  in   1  PS2_CLK pin level (async)
//  ps2_dat_in  in   1  PS2_DAT pin level (async)
//  ps2_clk_oe  out  1  1 = drive PS2_CLK low, 0 = release (top: PS2_CLK = oe?0:'bz)
//  ps2_dat_oe  out  1  1 = drive PS2_DAT low, 0 = release
//  rx_inhibit  out  1  high whenever state != IDLE; keyboard FSM ignores bus
//  tx_done     out  1  1-cycle pulse: frame sent, device ACK seen
//  tx_err      out  1  1-cycle pulse: NACK (data high at ACK) or watchdog expiry
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high. While reset is high and
//    in the cycle after, all outputs are 0 and state is IDLE. tx_ready is 1 from the
//    second cycle after reset deasserts.
//  - Pin inputs pass through 2-flop synchronizers; fall = prev 1, now 0 on the
//    synced clk.
//  - On accept: latch tx_data; parity = ~^tx_data (odd). Next state INHIBIT.
//  - INHIBIT: clk_oe=1, dat_oe=0 for exactly CLK_HZ/1e6*INHIBIT_US cycles.
//  - RTS: dat_oe=1 (start bit 0) for 1 cycle with clk_oe still 1. Then clk_oe=0,
//    watchdog starts, state SHIFT with bit index 0.
//  - SHIFT: on falls 1..8, dat_oe = ~data[i] (LSB first). On fall 9, dat_oe =
//    ~parity. On fall 10, dat_oe=0 (stop, line released). Go to ACK.
//  - ACK: on fall 11, sample synced dat: 0 -> WAIT_IDLE; 1 -> FAIL.
//  - WAIT_IDLE: wait for synced clk=1 and dat=1. Pulse tx_done. Go to IDLE.
//  - FAIL: dat_oe=clk_oe=0. Pulse tx_err. Go to IDLE.
//  - Watchdog (20-bit) expiry in SHIFT, ACK or WAIT_IDLE -> FAIL. Lines are
//    released the next cycle.
//  - tx_valid while busy is ignored; no queueing. A new accept is possible the
//    cycle after the done/err pulse.
//  - The host has priority: an accept while the device is mid-frame still inhibits.
//    The partial device frame is lost.
//  - Reset mid-transfer: both oe go to 0 on the next edge. No done/err pulse.
//  - Only edges of the synced clk advance SHIFT/ACK. Glitches shorter than 2 cycles
//    are filtered by the synchronizer.
// CONFIGURATION
//  PS2_TX_RETRY_EN defined: on the first FAIL, no tx_err is pulsed. The block
//    re-enters INHIBIT with the same byte and retries once. tx_err pulses only if
//    the retry also fails. tx_ready stays low throughout.
//  PS2_TX_RETRY_EN undefined: tx_err pulses on the first FAIL. No retry.
// TESTING (CLK_HZ=50e6, INHIBIT_US=120; device BFM clock period 80us)
//  1. Send 0xED -> clk_oe=1 for exactly 6000 cycles, then RTS. dat_oe on falls
//     1..9 = 0,1,0,0,1,0,0,0,0. BFM ACK -> one tx_done pulse, tx_err=0.
//  2. Send 0x00 -> data oe bits all 1, parity oe=0 (parity 1). Send 0x01 ->
//     parity oe=1 (parity 0). BFM decodes 0x00 and 0x01 with valid parity.
//  3. BFM leaves dat high at ACK -> one tx_err pulse. Both oe=0 the next cycle.
//     tx_ready=1 after that.
//  4. BFM never clocks -> tx_err exactly 750000 cycles after clk release.
//     With PS2_TX_RETRY_EN: a second INHIBIT, and tx_err only after 2 timeouts.
//  5. Assert reset at fall 5 of a 0xFF send -> oe=0 next cycle, no pulses. A new
//     0xFF send then completes with tx_done.
//  6. Pulse tx_valid with 0xAA during a busy 0xF4 send -> ignored. BFM receives
//     only 0xF4. rx_inhibit is high from accept to the done cycle.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift one byte on
// device clocks, check ACK. Optional single automatic retry via PS2_TX_RETRY_EN.
module ps2_host_tx #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned INHIBIT_US = 120,
    parameter int unsigned TIMEOUT_US = 15000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       rx_inhibit,
    output logic       tx_done,
    output logic       tx_err
);

    localparam int unsigned CYC_PER_US = CLK_HZ / 1000000;
    localparam logic [19:0] INH_LAST   = 20'(CYC_PER_US * INHIBIT_US - 1);
    localparam logic [19:0] WD_LAST    = 20'(CYC_PER_US * TIMEOUT_US - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE,
        S_FAIL
    } state_t;

    state_t      state_reg, state_next;
    logic [2:0]  clk_sync_reg;
    logic [1:0]  dat_sync_reg;
    logic [1:0]  init_reg;
    logic [7:0]  data_reg, data_next;
    logic        parity_reg, parity_next;
    logic [3:0]  bit_reg, bit_next;
    logic [19:0] timer_reg, timer_next;
    logic        dat_oe_reg, dat_oe_next;
`ifdef PS2_TX_RETRY_EN
    logic        retry_reg, retry_next;
`endif

    logic clk_s, dat_s, clk_fall, idle_ok, accept;

    // Bit 2 of the clock chain holds the previous synced level for edge detection.
    assign clk_s    = clk_sync_reg[1];
    assign dat_s    = dat_sync_reg[1];
    assign clk_fall = clk_sync_reg[2] & ~clk_sync_reg[1];
    assign idle_ok  = clk_s & dat_s;

    assign tx_ready   = (state_reg == S_IDLE) && init_reg[1];
    assign accept     = tx_valid && tx_ready;
    assign rx_inhibit = (state_reg != S_IDLE);
    assign ps2_clk_oe = (state_reg == S_INHIBIT) || (state_reg == S_RTS);
    assign ps2_dat_oe = (state_reg == S_RTS) || ((state_reg == S_SHIFT) && dat_oe_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_reg <= 3'b111;
            dat_sync_reg <= 2'b11;
            init_reg     <= 2'b00;
            state_reg    <= S_IDLE;
            data_reg     <= 8'h00;
            parity_reg   <= 1'b0;
            bit_reg      <= 4'd0;
            timer_reg    <= 20'd0;
            dat_oe_reg   <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retry_reg    <= 1'b0;
`endif
        end else begin
            clk_sync_reg <= {clk_sync_reg[1:0], ps2_clk_in};
            dat_sync_reg <= {dat_sync_reg[0], ps2_dat_in};
            init_reg     <= {init_reg[0], 1'b1};
            state_reg    <= state_next;
            data_reg     <= data_next;
            parity_reg   <= parity_next;
            bit_reg      <= bit_next;
            timer_reg    <= timer_next;
            dat_oe_reg   <= dat_oe_next;
`ifdef PS2_TX_RETRY_EN
            retry_reg    <= retry_next;
`endif
        end
    end

    always_comb begin
        state_next  = state_reg;
        data_next   = data_reg;
        parity_next = parity_reg;
        bit_next    = bit_reg;
        timer_next  = timer_reg;
        dat_oe_next = dat_oe_reg;
`ifdef PS2_TX_RETRY_EN
        retry_next  = retry_reg;
`endif
        tx_done     = 1'b0;
        tx_err      = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    data_next   = tx_data;
                    parity_next = ~^tx_data;
                    timer_next  = 20'd0;
                    state_next  = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retry_next  = 1'b0;
`endif
                end
            end
            S_INHIBIT: begin
                if (timer_reg == INH_LAST) begin
                    state_next = S_RTS;
                end else begin
                    timer_next = timer_reg + 20'd1;
                end
            end
            S_RTS: begin
                // Start bit stays driven after the clock line is released.
                state_next  = S_SHIFT;
                timer_next  = 20'd0;
                bit_next    = 4'd0;
                dat_oe_next = 1'b1;
            end
            S_SHIFT, S_ACK, S_WAIT_IDLE: begin
                timer_next = timer_reg + 20'd1;
                if ((state_reg == S_WAIT_IDLE) && idle_ok) begin
                    tx_done    = 1'b1;
                    state_next = S_IDLE;
                end else if (timer_reg == WD_LAST) begin
                    dat_oe_next = 1'b0;
                    state_next  = S_FAIL;
                end else if (clk_fall) begin
                    if (state_reg == S_SHIFT) begin
                        bit_next = bit_reg + 4'd1;
                        if (bit_reg < 4'd8) begin
                            dat_oe_next = ~data_reg[bit_reg[2:0]];
                        end else if (bit_reg == 4'd8) begin
                            dat_oe_next = ~parity_reg;
                        end else begin
                            dat_oe_next = 1'b0;
                            state_next  = S_ACK;
                        end
                    end else if (state_reg == S_ACK) begin
                        state_next = dat_s ? S_FAIL : S_WAIT_IDLE;
                    end
                end
            end
            S_FAIL: begin
                dat_oe_next = 1'b0;
`ifdef PS2_TX_RETRY_EN
                if (!retry_reg) begin
                    retry_next = 1'b1;
                    timer_next = 20'd0;
                    state_next = S_INHIBIT;
                end else begin
                    tx_err     = 1'b1;
                    state_next = S_IDLE;
                end
`else
                tx_err     = 1'b1;
                state_next = S_IDLE;
`endif
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule
